mux_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares the 2-bit four-input multiplexer between four requesters. It grants one requester at a time, drives the multiplexer `SEL`, and presents the selected 2-bit word on a valid/ready output with bounded burst length per grant. The block sits between four 2-bit producers and a single 2-bit consumer, and instantiates the existing `multiplexer` as its datapath.

---
 rtl/mux_rr_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one 2-bit 4:1 multiplexer between four
// requesters. One requester is granted at a time for at most BURST beats.
// The selected word is presented on a VALID/READY output.
//
// Handshake: a beat moves when VALID and READY are both high at a rising
// CLK edge. VALID never drops without a transfer, except on reset. While
// VALID=1 and READY=0, the granted requester holds its data stable.
// READY is don't-care while VALID=0.

// Combinational 2-bit 4:1 multiplexer (datapath).
module multiplexer (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic [1:0] C,
    input  logic [1:0] D,
    input  logic [1:0] SEL,
    output logic [1:0] X
);
    // Route the input chosen by SEL to X.
    always_comb begin
        X = A;
        case (SEL)
            2'd0:    X = A;
            2'd1:    X = B;
            2'd2:    X = C;
            default: X = D;
        endcase
    end
endmodule

module mux_rr_arbiter #(
    parameter int BURST = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic [1:0] C,
    input  logic [1:0] D,
    input  logic       READY,
    output logic [1:0] X,
    output logic       VALID,
    output logic [1:0] SEL,
    output logic [3:0] GNT,
    output logic       dbg_state_o,   // 0 = IDLE, 1 = BUSY
    output logic [1:0] dbg_ptr_o      // round-robin priority pointer
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [4:0] BURST_W = 5'(BURST);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;

    logic [1:0] mux_x;
    logic [2:0] arb_idle;    // {found, index} scanning from the current pointer
    logic [2:0] arb_next;    // {found, index} scanning from sel_q+1
    logic [1:0] ptr_next;
    logic [4:0] cnt_inc;

    // Scan req from ptr upward, wrapping mod 4. The first set bit wins.
    function automatic logic [2:0] arbitrate(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    multiplexer u_mux (
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D),
        .SEL (sel_q),
        .X   (mux_x)
    );

    assign VALID       = (state_q == BUSY);
    assign X           = VALID ? mux_x : 2'b00;
    assign SEL         = sel_q;
    assign GNT         = gnt_q;
    assign dbg_state_o = (state_q == BUSY);
    assign dbg_ptr_o   = ptr_q;

    assign ptr_next = sel_q + 2'd1;
    assign arb_idle = arbitrate(REQ, ptr_q);
    assign arb_next = arbitrate(REQ, ptr_next);
    assign cnt_inc  = {1'b0, cnt_q} + 5'd1;

    // Next-state: grant on request, keep or rotate the grant on each transfer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_idle[2]) begin
                    sel_d   = arb_idle[1:0];
                    gnt_d   = 4'b0001 << arb_idle[1:0];
                    cnt_d   = 4'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (READY) begin
                    cnt_d = cnt_inc[3:0];
                    if (!(REQ[sel_q] && (cnt_inc < BURST_W))) begin
                        // End of grant: the finished requester drops to lowest priority.
                        ptr_d = ptr_next;
                        if (arb_next[2]) begin
                            sel_d = arb_next[1:0];
                            gnt_d = 4'b0001 << arb_next[1:0];
                            cnt_d = 4'd0;
                        end else begin
                            gnt_d   = 4'b0000;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and arbitration registers, cleared asynchronously by RST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            gnt_q   <= 4'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
